// File: rtl/axi_req_arbiter.sv
// rtl/axi_req_arbiter.sv - merges AXI write/read address requests into one registered command slot
// Direction arbitration is sticky for up to RUN_MAX grants while the other side waits.

module axi_req_arbiter #(
  parameter int ADDRS   = 32,
  parameter int REQID   = 4,
  parameter int RUN_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             aw_valid_i,
  output logic             aw_ready_o,
  input  logic [7:0]       aw_len_i,
  input  logic [1:0]       aw_burst_i,
  input  logic [REQID-1:0] aw_id_i,
  input  logic [ADDRS-1:0] aw_addr_i,

  input  logic             ar_valid_i,
  output logic             ar_ready_o,
  input  logic [7:0]       ar_len_i,
  input  logic [1:0]       ar_burst_i,
  input  logic [REQID-1:0] ar_id_i,
  input  logic [ADDRS-1:0] ar_addr_i,

  output logic             avalid_o,
  input  logic             aready_i,
  output logic             awrite_o,
  output logic [7:0]       alen_o,
  output logic [1:0]       aburst_o,
  output logic [REQID-1:0] aid_o,
  output logic [ADDRS-1:0] aaddr_o
);

  localparam logic       DIR_READ  = 1'b0;
  localparam logic [7:0] RUN_LIMIT = 8'(RUN_MAX);
  localparam logic [7:0] RUN_SAT   = 8'hFF;

  logic       last_q;
  logic [7:0] run_q;
  logic       slot_open;
  logic       sel_write;
  logic       accept;

  // Only valids steer selection; a lone requester always wins regardless of run_q.
  always_comb begin
    slot_open = !avalid_o || aready_i;
    sel_write = aw_valid_i;
    if (aw_valid_i && ar_valid_i) begin
      sel_write = (run_q < RUN_LIMIT) ? last_q : !last_q;
    end
  end

  assign aw_ready_o = !reset && slot_open && aw_valid_i && sel_write;
  assign ar_ready_o = !reset && slot_open && ar_valid_i && !sel_write;
  assign accept     = aw_ready_o || ar_ready_o;

  always_ff @(posedge clock) begin
    if (reset) begin
      avalid_o <= 1'b0;
      last_q   <= DIR_READ;
      run_q    <= 8'd0;
    end else if (accept) begin
      avalid_o <= 1'b1;
      if (sel_write == last_q) begin
        run_q <= (run_q == RUN_SAT) ? run_q : run_q + 8'd1;
      end else begin
        last_q <= sel_write;
        run_q  <= 8'd1;
      end
    end else if (aready_i) begin
      avalid_o <= 1'b0;
    end
  end

  // Payload needs no reset: it is only meaningful while avalid_o is high.
  always_ff @(posedge clock) begin
    if (accept) begin
      awrite_o <= sel_write;
      alen_o   <= sel_write ? aw_len_i   : ar_len_i;
      aburst_o <= sel_write ? aw_burst_i : ar_burst_i;
      aid_o    <= sel_write ? aw_id_i    : ar_id_i;
      aaddr_o  <= sel_write ? aw_addr_i  : ar_addr_i;
    end
  end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// tb/tb_axi_req_arbiter.sv - randomized and directed bench for axi_req_arbiter against a behavioural model

module tb_axi_req_arbiter;

  localparam int ADDRS   = 32;
  localparam int REQID   = 4;
  localparam int RUN_MAX = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             aw_valid_i, aw_ready_o, ar_valid_i, ar_ready_o;
  logic [7:0]       aw_len_i, ar_len_i, alen_o;
  logic [1:0]       aw_burst_i, ar_burst_i, aburst_o;
  logic [REQID-1:0] aw_id_i, ar_id_i, aid_o;
  logic [ADDRS-1:0] aw_addr_i, ar_addr_i, aaddr_o;
  logic             avalid_o, aready_i, awrite_o;

  axi_req_arbiter #(.ADDRS(ADDRS), .REQID(REQID), .RUN_MAX(RUN_MAX)) dut (
    .clock(clock), .reset(reset),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_len_i(aw_len_i),
    .aw_burst_i(aw_burst_i), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_len_i(ar_len_i),
    .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .avalid_o(avalid_o), .aready_i(aready_i), .awrite_o(awrite_o),
    .alen_o(alen_o), .aburst_o(aburst_o), .aid_o(aid_o), .aaddr_o(aaddr_o)
  );

  always #5 clock = ~clock;

  int checks_total  = 0;
  int checks_passed = 0;

  // Behavioural model: direction history as plain ints plus the expected held command.
  logic             m_last;
  int               m_run;
  logic             m_av;
  logic [46:0]      m_cmd;

  function automatic logic [1:0] model_ready();
    logic want_write;
    if (reset) return 2'b00;
    if (m_av && !aready_i) return 2'b00;
    if (!aw_valid_i && !ar_valid_i) return 2'b00;
    if (aw_valid_i && ar_valid_i) want_write = (m_run < RUN_MAX) ? m_last : !m_last;
    else want_write = aw_valid_i;
    return want_write ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [46:0] dut_cmd();
    return {awrite_o, alen_o, aburst_o, aid_o, aaddr_o};
  endfunction

  // Advance one clock from the negedge and update the model with what should have happened.
  task automatic tick();
    logic [1:0] g;
    g = model_ready();
    @(posedge clock);
    if (reset) begin
      m_av = 1'b0; m_last = 1'b0; m_run = 0;
    end else if (g != 2'b00) begin
      m_av  = 1'b1;
      m_cmd = g[1] ? {1'b1, aw_len_i, aw_burst_i, aw_id_i, aw_addr_i}
                   : {1'b0, ar_len_i, ar_burst_i, ar_id_i, ar_addr_i};
      if (g[1] == m_last) m_run = (m_run >= 255) ? 255 : m_run + 1;
      else begin m_last = g[1]; m_run = 1; end
    end else if (aready_i) begin
      m_av = 1'b0;
    end
    #1;
  endtask

  task automatic rand_fields();
    aw_len_i = 8'($urandom); aw_burst_i = 2'($urandom); aw_id_i = REQID'($urandom); aw_addr_i = $urandom;
    ar_len_i = 8'($urandom); ar_burst_i = 2'($urandom); ar_id_i = REQID'($urandom); ar_addr_i = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1; aw_valid_i = 1'b0; ar_valid_i = 1'b0; aready_i = 1'b1;
    repeat (2) begin @(negedge clock); tick(); end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; aw_valid_i = 1'b1; ar_valid_i = 1'b1; aready_i = 1'b1; rand_fields();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks_total++;
      if ({aw_ready_o, ar_ready_o, avalid_o} !== 3'b000)
        $display("FAIL reset_state: got aw_rdy/ar_rdy/avalid=%b want 000", {aw_ready_o, ar_ready_o, avalid_o});
      else checks_passed++;
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    aw_valid_i = 1'b1; ar_valid_i = 1'b0; aready_i = 1'b1; rand_fields();
    aw_len_i = 8'h0F; aw_addr_i = 32'h1000;
    @(negedge clock);
    checks_total++;
    if ({aw_ready_o, ar_ready_o} !== 2'b10)
      $display("FAIL single_write_ready: got %b want 10", {aw_ready_o, ar_ready_o});
    else checks_passed++;
    tick();
    aw_valid_i = 1'b0;
    @(negedge clock);
    checks_total++;
    if ({avalid_o, awrite_o, aaddr_o, alen_o} !== {1'b1, 1'b1, 32'h1000, 8'h0F})
      $display("FAIL single_write_cmd: got v=%b w=%b addr=%h len=%h want v=1 w=1 addr=00001000 len=0f",
               avalid_o, awrite_o, aaddr_o, alen_o);
    else checks_passed++;
    tick();
    @(negedge clock);
    checks_total++;
    if (avalid_o !== 1'b0) $display("FAIL single_write_drop: got avalid=%b want 0", avalid_o);
    else checks_passed++;
    tick();
  endtask

  task automatic test_alternation();
    logic prev_w;
    do_reset();
    aw_valid_i = 1'b1; ar_valid_i = 1'b1; aready_i = 1'b1;
    prev_w = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rand_fields();
      @(negedge clock);
      checks_total++;
      if ({aw_ready_o, ar_ready_o} !== ((((i / RUN_MAX) % 2) == 1) ? 2'b10 : 2'b01))
        $display("FAIL alternation_grant[%0d]: got aw/ar=%b want write=%0d", i, {aw_ready_o, ar_ready_o}, (i / RUN_MAX) % 2);
      else checks_passed++;
      if (i > 0) begin
        checks_total++;
        if ({avalid_o, awrite_o} !== {1'b1, prev_w})
          $display("FAIL alternation_out[%0d]: got v/w=%b%b want 1%b", i, avalid_o, awrite_o, prev_w);
        else checks_passed++;
      end
      prev_w = ((i / RUN_MAX) % 2) == 1;
      tick();
    end
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    @(negedge clock); tick();
  endtask

  task automatic test_write_only();
    do_reset();
    aw_valid_i = 1'b1; ar_valid_i = 1'b0; aready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_fields();
      @(negedge clock);
      checks_total++;
      if ({aw_ready_o, ar_ready_o, avalid_o} !== {2'b10, (i != 0)})
        $display("FAIL write_only[%0d]: got aw/ar/v=%b want 10%b", i, {aw_ready_o, ar_ready_o, avalid_o}, (i != 0));
      else checks_passed++;
      tick();
    end
    aw_valid_i = 1'b0;
    @(negedge clock);
    checks_total++;
    if (dut.run_q !== 8'd10) $display("FAIL write_only_run: got run=%0d want 10", dut.run_q);
    else checks_passed++;
    tick();
    aw_valid_i = 1'b1; ar_valid_i = 1'b1;
    @(negedge clock);
    checks_total++;
    if ({aw_ready_o, ar_ready_o} !== 2'b01)
      $display("FAIL write_only_switch: got aw/ar=%b want 01", {aw_ready_o, ar_ready_o});
    else checks_passed++;
    tick();
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    @(negedge clock); tick();
  endtask

  task automatic test_stall();
    logic [46:0] held;
    do_reset();
    aw_valid_i = 1'b1; ar_valid_i = 1'b0; aready_i = 1'b0; rand_fields();
    @(negedge clock); tick();
    held = m_cmd;
    aw_valid_i = 1'b1; ar_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      @(negedge clock);
      checks_total++;
      if ({aw_ready_o, ar_ready_o, avalid_o} !== 3'b001 || dut_cmd() !== held)
        $display("FAIL stall[%0d]: got aw/ar/v=%b cmd=%h want 001 cmd=%h", i, {aw_ready_o, ar_ready_o, avalid_o}, dut_cmd(), held);
      else checks_passed++;
      tick();
    end
    aready_i = 1'b1;
    @(negedge clock);
    checks_total++;
    if ({aw_ready_o, ar_ready_o} !== model_ready() || (aw_ready_o ^ ar_ready_o) !== 1'b1)
      $display("FAIL stall_release: got aw/ar=%b want %b", {aw_ready_o, ar_ready_o}, model_ready());
    else checks_passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ar_valid_i = 1'b1; aw_valid_i = 1'b0; aready_i = 1'b0; rand_fields();
    @(negedge clock); tick();
    reset = 1'b1; aw_valid_i = 1'b1;
    @(negedge clock);
    checks_total++;
    if ({aw_ready_o, ar_ready_o, avalid_o} !== 3'b001)
      $display("FAIL reset_mid_cycle: got aw/ar/v=%b want 001", {aw_ready_o, ar_ready_o, avalid_o});
    else checks_passed++;
    tick();
    reset = 1'b0; aready_i = 1'b1;
    @(negedge clock);
    checks_total++;
    if ({aw_ready_o, ar_ready_o, avalid_o} !== 3'b010)
      $display("FAIL reset_mid_after: got aw/ar/v=%b want 010", {aw_ready_o, ar_ready_o, avalid_o});
    else checks_passed++;
    tick();
  endtask

  task automatic test_random();
    logic [1:0] exp_rdy;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 59) == 0);
      aw_valid_i = ($urandom_range(0, 99) < 60);
      ar_valid_i = ($urandom_range(0, 99) < 60);
      aready_i   = ($urandom_range(0, 99) < 70);
      rand_fields();
      @(negedge clock);
      exp_rdy = model_ready();
      checks_total++;
      if ({aw_ready_o, ar_ready_o} !== exp_rdy || avalid_o !== m_av || (m_av && dut_cmd() !== m_cmd))
        $display("FAIL random[%0d]: got aw/ar=%b v=%b cmd=%h want aw/ar=%b v=%b cmd=%h",
                 i, {aw_ready_o, ar_ready_o}, avalid_o, dut_cmd(), exp_rdy, m_av, m_cmd);
      else checks_passed++;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; aw_valid_i = 1'b0; ar_valid_i = 1'b0; aready_i = 1'b0;
    m_last = 1'b0; m_run = 0; m_av = 1'b0; m_cmd = '0;
    rand_fields();
    test_reset();
    test_single_write();
    test_alternation();
    test_write_only();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/axi_req_arbiter.md
AXI_REQ_ARBITER -- requirements
Module: axi_req_arbiter

Interface
REQ-001 Parameter ADDRS, 32, address width in bits.
REQ-002 Parameter REQID, 4, transaction-ID width in bits.
REQ-003 Parameter RUN_MAX, 4, maximum consecutive same-direction grants while the other direction is pending; legal range 1..255.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 aw_valid_i / aw_ready_o  input / output  1 / 1  write-address request handshake.
REQ-007 aw_len_i, aw_burst_i, aw_id_i, aw_addr_i  input  8, 2, REQID, ADDRS  write-address fields.
REQ-008 ar_valid_i / ar_ready_o  input / output  1 / 1  read-address request handshake.
REQ-009 ar_len_i, ar_burst_i, ar_id_i, ar_addr_i  input  8, 2, REQID, ADDRS  read-address fields.
REQ-010 avalid_o / aready_i  output / input  1 / 1  merged command handshake towards the chunk splitter.
REQ-011 awrite_o  output  1  1 = write command, 0 = read command.
REQ-012 alen_o, aburst_o, aid_o, aaddr_o  output  8, 2, REQID, ADDRS  registered copy of the granted request's fields.

Function
REQ-013 Output stage SHALL be a single register slot; slot is "open" when !avalid_o || aready_i.
REQ-014 Arbitration SHALL be combinational each cycle the slot is open; at most one of aw_ready_o, ar_ready_o SHALL be high in any cycle.
REQ-015 aw_ready_o SHALL be high only when the slot is open and write is selected; likewise ar_ready_o for read.
REQ-016 Selection: only one valid -> that one; both valid -> same direction as last grant if run_q < RUN_MAX, else opposite direction.
REQ-017 On an accepted request, next cycle: avalid_o=1, awrite_o = direction, alen/aburst/aid/aaddr = accepted fields, unmodified.
REQ-018 Latency SHALL be exactly one cycle from accept handshake to avalid_o.
REQ-019 avalid_o and all output fields SHALL remain stable while avalid_o && !aready_i.
REQ-020 On aready_i && avalid_o with no new accept, avalid_o SHALL fall to 0 next cycle; with a simultaneous accept, avalid_o SHALL stay 1 carrying the new request (back-to-back, no bubble).
REQ-021 State: last_q (1 bit, direction of last grant), run_q (8 bit count of consecutive grants in last_q direction).
REQ-022 On grant in same direction as last_q: run_q <= run_q+1, saturating at 255; on grant in opposite direction: last_q toggles, run_q <= 1.
REQ-023 run_q SHALL update only on an accept handshake; idle cycles SHALL NOT clear it.
REQ-024 A request with no competing requester SHALL be granted regardless of run_q (no forced switch when the other side is idle).
REQ-025 Requester inputs SHALL NOT be registered or inspected unless its valid is high; valid dropping without handshake SHALL cause no state change.

Reset
REQ-026 During reset: avalid_o=0, aw_ready_o=0, ar_ready_o=0, last_q=read, run_q=0; output fields SHALL be don't-care.
REQ-027 Reset asserted mid-transaction SHALL discard the held command; no handshake SHALL complete in the reset cycle.
REQ-028 First cycle after reset deasserts, arbitration SHALL operate normally (both valid -> read wins, as run_q=0 < RUN_MAX).

Verification
REQ-029 Single write, aw_len_i=8'h0F, aw_addr_i=32'h1000, aready_i=1 -> aw_ready_o high one cycle, next cycle avalid_o=1, awrite_o=1, aaddr_o=32'h1000, alen_o=8'h0F.
REQ-030 Both valid continuously, RUN_MAX=4, aready_i=1 -> grant pattern R,R,R,R,W,W,W,W,R..., avalid_o never drops.
REQ-031 Only aw_valid_i high for 10 requests, RUN_MAX=4 -> all 10 granted back-to-back, no forced switch; run_q=10.
REQ-032 avalid_o=1, aready_i held 0 for 5 cycles while both requesters valid -> both readies 0, output fields unchanged, then one accept on aready_i rise.
REQ-033 Reset asserted while avalid_o=1 and aready_i=0 -> avalid_o=0 next cycle, no handshake; after release, both valid -> read granted first.
